seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. It shares one external 4-bit-to-7-segment decoder across NUM_DIGITS digits by presenting each digit's nibble in turn, registering the returned pattern, and driving the one-hot digit enables. A blanking interval between digit slots removes ghosting. Display data is double-buffered and takes effect only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered digit data.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              num,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    upd_pending,
  output logic                    frame_start
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {DISP = 1'b0, BLANK = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]   pending_q, pending_d;
  logic                         upd_q, upd_d;
  logic [6:0]                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]        en_q, en_d;
  logic                         fs_q, fs_d;
  logic [NUM_DIGITS-1:0]        suppress;
  logic                         frame_bnd;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic lz_run;

  // A digit is dark when it and every more-significant digit hold zero.
  always_comb begin
    suppress = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run & (shadow_q[i] == 4'd0);
      suppress[i] = lz_run;
    end
  end
`else
  always_comb begin
    suppress = '0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    upd_d     = upd_q;
    seg_d     = '0;
    en_d      = '0;
    fs_d      = 1'b0;
    frame_bnd = 1'b0;

    case (state_q)
      DISP: begin
        if (!blank_mask[idx_q] && !suppress[idx_q]) begin
          seg_d       = seg_in;
          en_d[idx_q] = 1'b1;
        end
        if (cnt_q == DISP_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d   = DISP;
          cnt_d     = '0;
          frame_bnd = (idx_q == IDX_LAST);
          idx_d     = frame_bnd ? '0 : idx_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Shadow swaps before a coincident load lands, so the old pending is shown first.
    if (frame_bnd) begin
      fs_d = 1'b1;
      if (upd_q) begin
        shadow_d = pending_q;
        upd_d    = 1'b0;
      end
    end
    if (load) begin
      pending_d = data_in;
      upd_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DISP;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      upd_q     <= 1'b0;
      seg_q     <= '0;
      en_q      <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
      fs_q      <= fs_d;
    end
  end

  assign num         = shadow_q[idx_q];
  assign seg_out     = seg_q;
  assign dig_en      = en_q;
  assign upd_pending = upd_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: table vectors, hand sequences and random stimulus
// checked every cycle against a time-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  num;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        upd_pending;
  logic        frame_start;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  logic [3:0] sh_m [ND];
  logic [3:0] pd_m [ND];
  logic       pflag_m;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
    .num        (num),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .upd_pending(upd_pending),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  always_comb seg_in = dec(num);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge: predict outputs from the frame position and the model buffers.
  task automatic tick();
    int k, s, d, off;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       bnd, sup;
    k   = edge_n;
    s   = k % FRAME;
    d   = s / SLOT;
    off = s % SLOT;
    sup = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    sup = (d != 0);
    for (int j = d; j < ND; j++) if (sh_m[j] != 4'd0) sup = 1'b0;
`endif
    e_en  = '0;
    e_seg = '0;
    if (off < RD && !blank_mask[d] && !sup) begin
      e_en  = 4'(1 << d);
      e_seg = dec(sh_m[d]);
    end
    bnd = (s == FRAME - 1);
    if (bnd && pflag_m) begin
      for (int j = 0; j < ND; j++) sh_m[j] = pd_m[j];
      pflag_m = 1'b0;
    end
    if (load) begin
      for (int j = 0; j < ND; j++) pd_m[j] = data_in[4*j +: 4];
      pflag_m = 1'b1;
    end
    edge_n++;
    @(posedge clk);
    #1;
    chk("dig_en", 32'(dig_en), 32'(e_en));
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("frame_start", 32'(frame_start), 32'(bnd));
    chk("upd_pending", 32'(upd_pending), 32'(pflag_m));
    chk("num", 32'(num), 32'(sh_m[((k + 1) % FRAME) / SLOT]));
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    #1;
    chk("rst_seg_out", 32'(seg_out), 32'd0);
    chk("rst_dig_en", 32'(dig_en), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_upd_pending", 32'(upd_pending), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_dig_en", 32'(dig_en), 32'd0);
    rst     = 1'b0;
    edge_n  = 0;
    pflag_m = 1'b0;
    for (int j = 0; j < ND; j++) begin
      sh_m[j] = 4'd0;
      pd_m[j] = 4'd0;
    end
  endtask

  // Returns just after the edge that raises frame_start with no update still pending.
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(frame_start === 1'b1 && !pflag_m) && n < 200);
    chk("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
    logic [27:0] segs;
    logic [3:0]  lit;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0000, 4'b0000, {4{7'b0111111}}, 4'b1111};
    vecs[1] = '{16'h1234, 4'b0000,
                {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b1111};
    vecs[2] = '{16'h8888, 4'b0100, {4{7'b1111111}}, 4'b1011};
    vecs[3] = '{16'h0070, 4'b0000,
                {7'b0111111, 7'b0111111, 7'b0000111, 7'b0111111}, 4'b1111};
    vecs[4] = '{16'hFEDC, 4'b1001,
                {7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001}, 4'b0110};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vecs[0].lit = 4'b0001;
    vecs[3].lit = 4'b0011;
`endif

    #1;
    do_reset();

    // Idle after reset: zeros scanned, first frame_start after one full frame.
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      if (i == 1) begin
        chk("idle_d0_en", 32'(dig_en), 32'b0001);
        chk("idle_d0_seg", 32'(seg_out), 32'b0111111);
      end
      if (i == 8)  chk("idle_d0_last", 32'(dig_en), 32'b0001);
      if (i == 9)  chk("idle_blank", 32'(dig_en), 32'b0000);
      if (i == 11) chk("idle_d1_en", 32'(dig_en), 32'b0010);
      if (i == 39) chk("idle_no_fs", 32'(frame_start), 32'd0);
      if (i == 40) chk("idle_first_fs", 32'(frame_start), 32'd1);
    end

    // Table vectors: load, wait for the frame that shows it, inspect each slot.
    for (int v = 0; v < 5; v++) begin
      blank_mask = vecs[v].mask;
      data_in    = vecs[v].data;
      load       = 1'b1;
      tick();
      load       = 1'b0;
      chk("tbl_upd_after_load", 32'(upd_pending), 32'd1);
      wait_frame();
      chk("tbl_upd_cleared", 32'(upd_pending), 32'd0);
      for (int d = 0; d < ND; d++) begin
        if (d == 0) tick();
        else repeat (SLOT) tick();
        chk("tbl_dig_en", 32'(dig_en), vecs[v].lit[d] ? 32'(1 << d) : 32'd0);
        chk("tbl_seg_out", 32'(seg_out), vecs[v].lit[d] ? 32'(vecs[v].segs[7*d +: 7]) : 32'd0);
      end
    end
    blank_mask = '0;

    // Two loads in one frame: only the last is shown.
    wait_frame();
    repeat (3) tick();
    data_in = 16'hAAAA; load = 1'b1; tick(); load = 1'b0;
    repeat (5) tick();
    data_in = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    chk("dbl_upd", 32'(upd_pending), 32'd1);
    wait_frame();
    tick();
    chk("dbl_last_wins", 32'(seg_out), 32'b1101101);
    chk("dbl_en", 32'(dig_en), 32'b0001);

    // Load on the exact boundary cycle: old pending this frame, new one next.
    data_in = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    while (edge_n % FRAME != FRAME - 1) tick();
    data_in = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    chk("bnd_fs", 32'(frame_start), 32'd1);
    chk("bnd_upd_stays", 32'(upd_pending), 32'd1);
    tick();
    chk("bnd_old_pending", 32'(seg_out), 32'b0000110);
    wait_frame();
    tick();
    chk("bnd_new_pending", 32'(seg_out), 32'b1011011);

    // Reset 17 cycles into a frame with an update pending.
    wait_frame();
    data_in = 16'h9999; load = 1'b1; tick(); load = 1'b0;
    repeat (16) tick();
    do_reset();
    chk("mid_rst_upd", 32'(upd_pending), 32'd0);
    wait_frame();
    tick();
    chk("mid_rst_zero_shown", 32'(seg_out), 32'b0111111);
    chk("mid_rst_en", 32'(dig_en), 32'b0001);

    // Random loads and masks against the model.
    repeat (800) begin
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
        load    = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
      tick();
      load = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
